// File: rtl/bnn_pkg.sv
// Shared constants, FSM state encoding and datapath types for the BNN output stage.
// Pure declarations: no logic, no latency, no flow control.
package bnn_pkg;

  localparam int IMG_BITS    = 784;
  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 10;
  localparam int CLASS_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [CLASS_W-1:0] class_t;

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count built as a balanced binary adder tree; zero latency.
// No flow control: output follows the input within the same cycle.
module popcount_tree #(
  parameter int WIDTH = 784,
  parameter int OUT_W = 10
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [OUT_W-1:0] count_o
);

  if (WIDTH == 1) begin : g_leaf
    assign count_o = OUT_W'(bits_i);
  end else begin : g_node
    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    logic [OUT_W-1:0] lo_cnt;
    logic [OUT_W-1:0] hi_cnt;

    popcount_tree #(.WIDTH(LO_W), .OUT_W(OUT_W)) u_lo (
      .bits_i  (bits_i[LO_W-1:0]),
      .count_o (lo_cnt)
    );

    popcount_tree #(.WIDTH(HI_W), .OUT_W(OUT_W)) u_hi (
      .bits_i  (bits_i[WIDTH-1:LO_W]),
      .count_o (hi_cnt)
    );

    // OUT_W is sized to hold WIDTH, so partial sums never wrap.
    assign count_o = lo_cnt + hi_cnt;
  end

endmodule

// File: rtl/bnn_classifier.sv
// BNN argmax stage: scans weight rows 0..NUM_CLASSES-1, scores XNOR-popcount, 12 cycles accept-to-result.
// Accepts one image only in IDLE; result is held in DONE until the consumer takes it.
module bnn_classifier #(
  parameter int IMG_BITS    = 784,
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 10,
  parameter int CLASS_W     = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                valid_i,
  input  logic [IMG_BITS-1:0] image_i,
  output logic                ready_o,
  output logic [CLASS_W-1:0]  rom_addr_o,
  input  logic [IMG_BITS-1:0] weight_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [CLASS_W-1:0]  class_o,
  output logic [SCORE_W-1:0]  score_o
);

  import bnn_pkg::*;

  localparam logic [CLASS_W-1:0] LAST_ADDR = CLASS_W'(NUM_CLASSES - 1);

  state_e               state_q, state_d;
  logic [IMG_BITS-1:0]  image_q, image_d;
  logic [CLASS_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [CLASS_W-1:0]   cmp_idx_q, cmp_idx_d;
  logic                 cmp_vld_q, cmp_vld_d;
  logic [SCORE_W-1:0]   best_score_q, best_score_d;
  logic [CLASS_W-1:0]   best_class_q, best_class_d;

  logic                 accept;
  logic [IMG_BITS-1:0]  match_bits;
  logic [SCORE_W-1:0]   row_score;

  assign match_bits = ~(image_q ^ weight_i);

  popcount_tree #(.WIDTH(IMG_BITS), .OUT_W(SCORE_W)) u_popcount (
    .bits_i  (match_bits),
    .count_o (row_score)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = SCAN;
      SCAN:    if (addr_cnt_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pure decodes of registered state and counter
  always_comb begin
    ready_o    = (state_q == IDLE);
    valid_o    = (state_q == DONE);
    rom_addr_o = (state_q == SCAN) ? addr_cnt_q : '0;
    accept     = valid_i && (state_q == IDLE);
    class_o    = best_class_q;
    score_o    = best_score_q;
  end

  // Datapath next-state: address walk, one-cycle compare delay, best-so-far
  always_comb begin
    image_d      = accept ? image_i : image_q;
    addr_cnt_d   = '0;
    cmp_vld_d    = (state_q == SCAN);
    cmp_idx_d    = addr_cnt_q;
    best_score_d = best_score_q;
    best_class_d = best_class_q;

    if ((state_q == SCAN) && (addr_cnt_q != LAST_ADDR)) begin
      addr_cnt_d = addr_cnt_q + CLASS_W'(1);
    end

    // Strict compare keeps the lowest index on ties; row 0 always seeds the result.
    if (accept) begin
      best_score_d = '0;
      best_class_d = '0;
    end else if (cmp_vld_q && ((cmp_idx_q == '0) || (row_score > best_score_q))) begin
      best_score_d = row_score;
      best_class_d = cmp_idx_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      addr_cnt_q   <= '0;
      cmp_vld_q    <= 1'b0;
      cmp_idx_q    <= '0;
      best_score_q <= '0;
      best_class_q <= '0;
    end else begin
      addr_cnt_q   <= addr_cnt_d;
      cmp_vld_q    <= cmp_vld_d;
      cmp_idx_q    <= cmp_idx_d;
      best_score_q <= best_score_d;
      best_class_q <= best_class_d;
    end
  end

  // Image register is only meaningful after an accept, so it carries no reset.
  always_ff @(posedge clk_i) begin
    image_q <= image_d;
  end

endmodule

// File: tb/tb_bnn_classifier.sv
// Bench for bnn_classifier: directed vector table, stall/reset sequences and random frames
// scored by an argmax-of-match-counts reference model; registered ROM modelled locally.
module tb_bnn_classifier;

  import bnn_pkg::*;

  typedef logic [IMG_BITS-1:0]                   img_t;
  typedef logic [NUM_CLASSES-1:0][IMG_BITS-1:0]  rows_t;

  typedef struct {
    img_t  img;
    rows_t rows;
    int    exp_cls;
    int    exp_score;
  } vec_t;

  logic               clk;
  logic               reset_i;
  logic               valid_i;
  img_t               image_i;
  logic               ready_o;
  logic [CLASS_W-1:0] rom_addr_o;
  img_t               weight;
  logic               valid_o;
  logic               ready_i;
  logic [CLASS_W-1:0] class_o;
  logic [SCORE_W-1:0] score_o;

  img_t               pc_in;
  logic [SCORE_W-1:0] pc_out;

  img_t rom_mem [16];

  int checks   = 0;
  int failures = 0;

  bnn_classifier #(
    .IMG_BITS(IMG_BITS), .NUM_CLASSES(NUM_CLASSES), .SCORE_W(SCORE_W), .CLASS_W(CLASS_W)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .valid_i    (valid_i),
    .image_i    (image_i),
    .ready_o    (ready_o),
    .rom_addr_o (rom_addr_o),
    .weight_i   (weight),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .class_o    (class_o),
    .score_o    (score_o)
  );

  popcount_tree #(.WIDTH(IMG_BITS), .OUT_W(SCORE_W)) u_pc (
    .bits_i  (pc_in),
    .count_o (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM; its active-high reset is the inverse of the block reset.
  always @(posedge clk) begin
    if (!reset_i) weight <= '0;
    else          weight <= rom_mem[rom_addr_o];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic img_t ones(input int n);
    img_t r;
    for (int i = 0; i < IMG_BITS; i++) r[i] = (i < n);
    return r;
  endfunction

  function automatic img_t rand_img();
    img_t r = '0;
    for (int i = 0; i < 25; i++) r = {r[IMG_BITS-33:0], 32'($urandom)};
    return r;
  endfunction

  // Reference: match count per class, then the first class reaching the maximum.
  task automatic model(input img_t img, input rows_t rows, output int cls, output int sc);
    int s [NUM_CLASSES];
    int mx = -1;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      s[k] = $countones(~(img ^ rows[k]));
      if (s[k] > mx) mx = s[k];
    end
    cls = -1;
    for (int k = NUM_CLASSES - 1; k >= 0; k--) if (s[k] == mx) cls = k;
    sc = mx;
  endtask

  task automatic load_rom(input rows_t rows);
    for (int k = 0; k < 16; k++) rom_mem[k] = (k < NUM_CLASSES) ? rows[k] : '0;
  endtask

  // Offer an image and return at the negedge of T1 after the input handshake.
  task automatic start(input img_t img);
    int guard = 0;
    @(negedge clk);
    valid_i = 1'b1;
    image_i = img;
    while (!ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_o) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    image_i = rand_img();
  endtask

  // From the negedge of cycle T(n0), follow the address walk until valid_o and check the result.
  task automatic wait_result(input int n0, input int exp_cls, input int exp_sc, input string nm);
    int n = n0;
    int addr_bad = 0;
    int exp_a;
    for (int g = 0; g < 40; g++) begin
      if (valid_o) break;
      exp_a = (n >= 1 && n <= NUM_CLASSES) ? n - 1 : 0;
      if (int'(rom_addr_o) != exp_a) addr_bad++;
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, valid_o ? n : -1, 12);
    chk({nm, "_addr_seq_errors"}, addr_bad, 0);
    chk({nm, "_class"}, int'(class_o), exp_cls);
    chk({nm, "_score"}, int'(score_o), exp_sc);
    chk({nm, "_ready_in_done"}, int'(ready_o), 0);
  endtask

  task automatic handshake(input string nm);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk({nm, "_ready_after_hs"}, int'(ready_o), 1);
    chk({nm, "_valid_after_hs"}, int'(valid_o), 0);
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    load_rom(v.rows);
    start(v.img);
    wait_result(1, v.exp_cls, v.exp_score, nm);
    handshake(nm);
  endtask

  vec_t vecs [6];

  initial begin
    vec_t  rv;
    int    cls, sc, a, b;
    img_t  img_b;

    reset_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    image_i = '0;
    pc_in   = '0;
    for (int k = 0; k < 16; k++) rom_mem[k] = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_addr", int'(rom_addr_o), 0);
    chk("rst_class", int'(class_o), 0);
    chk("rst_score", int'(score_o), 0);
    reset_i = 1'b1;

    pc_in = '0;        #1 chk("pc_zeros", int'(pc_out), 0);
    pc_in = '1;        #1 chk("pc_ones", int'(pc_out), IMG_BITS);
    pc_in = img_t'(1); #1 chk("pc_bit0", int'(pc_out), 1);
    pc_in = '0; pc_in[IMG_BITS-1] = 1'b1;
    #1 chk("pc_msb", int'(pc_out), 1);
    pc_in = rand_img(); #1 chk("pc_rand", int'(pc_out), $countones(pc_in));

    vecs[0].img = '1;
    for (int k = 0; k < NUM_CLASSES; k++) vecs[0].rows[k] = (k == 3) ? '1 : '0;
    vecs[0].exp_cls = 3; vecs[0].exp_score = 784;

    vecs[1].img = '0;
    for (int k = 0; k < NUM_CLASSES; k++) vecs[1].rows[k] = '1;
    vecs[1].rows[7] = '0; vecs[1].rows[2] = ones(100);
    vecs[1].exp_cls = 7; vecs[1].exp_score = 784;

    vecs[2].img = '1;
    for (int k = 0; k < NUM_CLASSES; k++) vecs[2].rows[k] = ones(392);
    vecs[2].exp_cls = 0; vecs[2].exp_score = 392;

    vecs[3].img = '1;
    for (int k = 0; k < NUM_CLASSES; k++) vecs[3].rows[k] = (k <= 5) ? ones(k * 50) : ones(100);
    vecs[3].rows[8] = ones(250);
    vecs[3].exp_cls = 5; vecs[3].exp_score = 250;

    vecs[4].img = ones(392);
    for (int k = 0; k < NUM_CLASSES; k++) vecs[4].rows[k] = '0;
    vecs[4].rows[9] = ones(392);
    vecs[4].exp_cls = 9; vecs[4].exp_score = 784;

    vecs[5].img = '0;
    for (int k = 0; k < NUM_CLASSES; k++) vecs[5].rows[k] = '1;
    vecs[5].exp_cls = 0; vecs[5].exp_score = 0;

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Output stall with a second image waiting on the input.
    load_rom(vecs[1].rows);
    start(vecs[1].img);
    wait_result(1, 7, 784, "stallA");
    load_rom(vecs[3].rows);
    valid_i = 1'b1;
    image_i = vecs[3].img;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", int'(valid_o), 1);
      chk("stall_class", int'(class_o), 7);
      chk("stall_score", int'(score_o), 784);
      chk("stall_ready", int'(ready_o), 0);
    end
    handshake("stallA");
    @(negedge clk);
    valid_i = 1'b0;
    image_i = rand_img();
    chk("stallB_busy", int'(ready_o), 0);
    wait_result(1, 5, 250, "stallB");
    handshake("stallB");

    // Reset during T6 of a scan.
    load_rom(vecs[0].rows);
    start(vecs[0].img);
    repeat (5) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    chk("abort_valid", int'(valid_o), 0);
    chk("abort_addr", int'(rom_addr_o), 0);
    chk("abort_ready", int'(ready_o), 1);
    chk("abort_score", int'(score_o), 0);
    run_frame(vecs[4], "after_abort");

    for (int i = 0; i < 24; i++) begin
      rv.img = rand_img();
      for (int k = 0; k < NUM_CLASSES; k++) rv.rows[k] = rand_img();
      case ($urandom_range(0, 3))
        1: begin
          a = $urandom_range(0, NUM_CLASSES - 2);
          b = $urandom_range(a + 1, NUM_CLASSES - 1);
          img_b = rv.img;
          img_b[$urandom_range(0, IMG_BITS - 1)] ^= 1'b1;
          rv.rows[a] = img_b;
          rv.rows[b] = img_b;
        end
        2: rv.rows[$urandom_range(0, NUM_CLASSES - 1)] = rv.img;
        3: for (int k = 1; k < NUM_CLASSES; k++) rv.rows[k] = rv.rows[0];
        default: ;
      endcase
      model(rv.img, rv.rows, cls, sc);
      rv.exp_cls   = cls;
      rv.exp_score = sc;
      run_frame(rv, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
